// File: rtl/bcd_display_sched.sv
// Shares one free-running binary-to-BCD converter between score and timer requesters,
// latches the two-digit results and scans the four digits onto the seven-segment bus.
module bcd_display_sched #(
    parameter int CONV_WAIT = 14,
    parameter int SCAN_DIV  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  score,
    input  logic        score_req,
    input  logic [5:0]  timer,
    input  logic        timer_req,
    input  logic [11:0] conv_bcd,
    output logic [5:0]  conv_bin,
    output logic [7:0]  score_bcd,
    output logic [7:0]  timer_bcd,
    output logic        score_ack,
    output logic        timer_ack,
    output logic        busy,
    output logic [3:0]  digit_an,
    output logic [3:0]  digit_val
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

    state_t      state, state_n;
    logic        pend_s, pend_t;
    logic        last_grant;      // 1 = timer was granted last
    logic        pick_t;
    logic        any_pend;
    logic [5:0]  score_val, timer_val;
    logic [7:0]  wcnt;
    logic [15:0] scan_cnt;
    logic [1:0]  idx;
    logic        unused_hund;

    // Hundreds digit is always zero for 6-bit inputs.
    assign unused_hund = ^conv_bcd[11:8];

    assign any_pend = pend_s | pend_t;
    assign pick_t   = pend_t & (~pend_s | ~last_grant);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_pend) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (wcnt == 8'd0) state_n = STORE;
            STORE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pend_s     <= 1'b0;
            pend_t     <= 1'b0;
            last_grant <= 1'b1;
            score_val  <= 6'd0;
            timer_val  <= 6'd0;
            conv_bin   <= 6'd0;
            wcnt       <= 8'd0;
            score_bcd  <= 8'd0;
            timer_bcd  <= 8'd0;
        end else begin
            state <= state_n;
            // A fresh request re-arms the flag even in the cycle it is granted.
            pend_s <= score_req | (pend_s & ~(state == IDLE && !pick_t));
            pend_t <= timer_req | (pend_t & ~(state == IDLE && pick_t));
            if (score_req) score_val <= score;
            if (timer_req) timer_val <= timer;
            case (state)
                IDLE: if (any_pend) begin
                    last_grant <= pick_t;
                    conv_bin   <= pick_t ? timer_val : score_val;
                end
                ISSUE: wcnt <= 8'(CONV_WAIT - 1);
                WAIT:  if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
                STORE: begin
                    if (last_grant) timer_bcd <= conv_bcd[7:0];
                    else            score_bcd <= conv_bcd[7:0];
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign score_ack = (state == STORE) & ~last_grant;
    assign timer_ack = (state == STORE) &  last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= 16'd0;
            idx      <= 2'd0;
        end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
            scan_cnt <= 16'd0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    always_comb begin
        digit_an  = 4'b1110;
        digit_val = score_bcd[3:0];
        case (idx)
            2'd1: begin digit_an = 4'b1101; digit_val = score_bcd[7:4]; end
            2'd2: begin digit_an = 4'b1011; digit_val = timer_bcd[3:0]; end
            2'd3: begin digit_an = 4'b0111; digit_val = timer_bcd[7:4]; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bcd_display_sched.sv
// Scoreboard bench: stimulus queues expected acks/results, a monitor pops and checks them.
module tb_bcd_display_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  score = 6'd0, timer = 6'd0;
    logic        score_req = 1'b0, timer_req = 1'b0;
    logic [11:0] conv_bcd = 12'd0;
    logic [5:0]  conv_bin;
    logic [7:0]  score_bcd, timer_bcd;
    logic        score_ack, timer_ack, busy;
    logic [3:0]  digit_an, digit_val;

    bcd_display_sched #(.CONV_WAIT(14), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .score(score), .score_req(score_req),
        .timer(timer), .timer_req(timer_req), .conv_bcd(conv_bcd),
        .conv_bin(conv_bin), .score_bcd(score_bcd), .timer_bcd(timer_bcd),
        .score_ack(score_ack), .timer_ack(timer_ack), .busy(busy),
        .digit_an(digit_an), .digit_val(digit_val)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running converter: new result every 6-cycle frame.
    logic [2:0] fr = 3'd0;
    always @(posedge clk) begin
        fr <= (fr == 3'd5) ? 3'd0 : fr + 3'd1;
        if (fr == 3'd5) conv_bcd <= {4'd0, 4'(conv_bin / 6'd10), 4'(conv_bin % 6'd10)};
    end

    typedef struct {
        bit         t;
        logic [7:0] v;
        int         cyc;
    } sb_t;
    sb_t q[$];

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor
    bit         bcd_pend = 0;
    bit         bcd_t;
    logic [7:0] bcd_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (bcd_pend) begin
                chk(bcd_t ? "timer_bcd" : "score_bcd", bcd_t ? timer_bcd : score_bcd, bcd_exp);
                bcd_pend = 0;
            end
            if (score_ack || timer_ack) begin
                chk("ack_overlap", int'(score_ack & timer_ack), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: score_ack=%0b timer_ack=%0b with empty queue at cycle %0d",
                             score_ack, timer_ack, cyc);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    chk("ack_who", int'(timer_ack), int'(e.t));
                    if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
                    bcd_t    = e.t;
                    bcd_exp  = e.v;
                    bcd_pend = 1;
                end
            end
        end
    end

    // Pulse requests for one cycle; k is the edge that samples them.
    task automatic req(input bit s, input logic [5:0] sv, input bit t, input logic [5:0] tv,
                       output int k);
        @(posedge clk); #1;
        score_req = s; score = sv;
        timer_req = t; timer = tv;
        @(posedge clk); #1;
        k = cyc;
        score_req = 1'b0; timer_req = 1'b0;
    endtask

    task automatic push(input bit t, input logic [7:0] v, input int c);
        sb_t e;
        e.t = t; e.v = v; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(q.size() != 0), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    logic [3:0] exp_an[4];
    logic [3:0] exp_val[4];

    initial begin
        int k, k2;
        logic [3:0] prev;
        bit found;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_conv_bin", conv_bin, 0);
        chk("rst_score_bcd", score_bcd, 0);
        chk("rst_timer_bcd", timer_bcd, 0);
        chk("rst_acks", {score_ack, timer_ack}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_digit_an", digit_an, 4'b1110);
        chk("rst_digit_val", digit_val, 0);
        reset = 1'b1;

        // Single request
        req(1, 6'd47, 0, 6'd0, k);
        push(0, 8'h47, k + 16);
        repeat (3) @(negedge clk);
        chk("single_busy", busy, 1);
        chk("single_conv_bin", conv_bin, 47);
        drain();
        chk("single_timer_untouched", timer_bcd, 8'h00);
        chk("single_busy_done", busy, 0);

        // Tie after reset: score first, then timer 17 cycles later
        do_reset();
        req(1, 6'd9, 1, 6'd63, k);
        push(0, 8'h09, k + 16);
        push(1, 8'h63, k + 33);
        drain();

        // Make score the last grant, then a tie goes to timer first
        req(1, 6'd12, 0, 6'd0, k);
        push(0, 8'h12, k + 16);
        drain();
        req(1, 6'd1, 1, 6'd2, k);
        push(1, 8'h02, k + 16);
        push(0, 8'h01, k + 33);
        drain();

        // Overwrite while pending: one score conversion with the latest value
        req(0, 6'd0, 1, 6'd40, k);
        push(1, 8'h40, k + 16);
        repeat (2) @(posedge clk);
        req(1, 6'd10, 0, 6'd0, k2);
        repeat (4) @(posedge clk);
        req(1, 6'd20, 0, 6'd0, k2);
        push(0, 8'h20, k + 33);
        drain();

        // Request during own conversion
        req(0, 6'd0, 1, 6'd30, k);
        push(1, 8'h30, k + 16);
        repeat (5) @(posedge clk);
        req(0, 6'd0, 1, 6'd29, k2);
        push(1, 8'h29, k + 33);
        drain();

        // Scan
        req(1, 6'd47, 0, 6'd0, k);
        push(0, 8'h47, k + 16);
        drain();
        req(0, 6'd0, 1, 6'd59, k);
        push(1, 8'h59, k + 16);
        drain();
        exp_an[0] = 4'b1110; exp_val[0] = 4'd7;
        exp_an[1] = 4'b1101; exp_val[1] = 4'd4;
        exp_an[2] = 4'b1011; exp_val[2] = 4'd9;
        exp_an[3] = 4'b0111; exp_val[3] = 4'd5;
        found = 0;
        @(negedge clk);
        prev = digit_an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && digit_an == 4'b1110) found = 1;
            else prev = digit_an;
        end
        chk("scan_sync_found", int'(found), 1);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                for (int c = 0; c < 4; c++) begin
                    chk("scan_an", digit_an, exp_an[p]);
                    chk("scan_val", digit_val, exp_val[p]);
                    @(negedge clk);
                end

        // Reset during WAIT: no ack, everything back to reset values
        req(0, 6'd0, 1, 6'd11, k);
        repeat (6) @(posedge clk);
        #1;
        chk("midwait_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_conv_bin", conv_bin, 0);
        chk("midrst_score_bcd", score_bcd, 0);
        chk("midrst_timer_bcd", timer_bcd, 0);
        chk("midrst_acks", {score_ack, timer_ack}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_digit_an", digit_an, 4'b1110);
        chk("midrst_digit_val", digit_val, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
        end

        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
